// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter.
//   cdb_entry_t : one queued result {data, preg, rob_tag, mispredict} at the
//                 default widths; the top builds an equivalent struct from its
//                 own parameters and hands it to each queue as a type parameter.
//   NUM_CDB_SRC : number of producing functional units.
//   SRC_*       : source index of each functional unit.
//   src_next    : next source index, wrapping from the last source to the first.
package cdb_arbiter_pkg;

  localparam int CDB_XLEN      = 32;
  localparam int CDB_PREG_W    = 6;
  localparam int CDB_ROB_TAG_W = 4;

  localparam int NUM_CDB_SRC = 3;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_LSU = 2'd1;
  localparam src_idx_t SRC_BR  = 2'd2;

  typedef struct packed {
    logic [CDB_XLEN-1:0]      data;
    logic [CDB_PREG_W-1:0]    preg;
    logic [CDB_ROB_TAG_W-1:0] rob_tag;
    logic                     mispredict;
  } cdb_entry_t;

  function automatic src_idx_t src_next(input src_idx_t s);
    return (s == SRC_BR) ? SRC_ALU : s + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source result FIFO feeding the CDB arbiter.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : empties the queue; a push in the same cycle is dropped
//   push        : producer valid; taken only when ready
//   push_entry  : entry to enqueue
//   pop         : arbiter grant; removes the head
//   ready       : queue not full, from the registered count only
//   head        : oldest entry
//   nonempty    : at least one entry held
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module cdb_src_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = cdb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   ready,
  output entry_t head,
  output logic   nonempty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses even when it is popped in the same cycle, which keeps
  // grant logic out of the ready path.
  assign ready    = (count != CNT_W'(DEPTH));
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  assign do_push = push && ready && !flush;
  assign do_pop  = pop && nonempty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; only entries below the count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from the ALU, LSU and branch unit
// and broadcasts one per cycle on the CDB, round-robin between sources.
//   clk, reset      : clock, synchronous active-high reset (wins over flush_i)
//   flush_i         : drops every queued result and any push this cycle
//   alu_cdb_*       : ALU result handshake and fields
//   lsu_cdb_*       : LSU result handshake and fields (stores use preg 0)
//   br_*            : branch resolution; queued with data = target, preg = 0
//   cdb_valid       : a result is on the bus this cycle
//   cdb_data/preg/rob_tag/mispredict : broadcast fields, all 0 when idle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN      = CDB_XLEN,
  parameter int PREG_W    = CDB_PREG_W,
  parameter int ROB_TAG_W = CDB_ROB_TAG_W,
  parameter int QDEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 alu_cdb_valid,
  output logic                 alu_cdb_ready,
  input  logic [XLEN-1:0]      alu_cdb_data,
  input  logic [PREG_W-1:0]    alu_cdb_preg,
  input  logic [ROB_TAG_W-1:0] alu_cdb_tag,
  input  logic                 lsu_cdb_valid,
  output logic                 lsu_cdb_ready,
  input  logic [XLEN-1:0]      lsu_cdb_data,
  input  logic [PREG_W-1:0]    lsu_cdb_preg,
  input  logic [ROB_TAG_W-1:0] lsu_cdb_tag,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [ROB_TAG_W-1:0] br_rob_tag,
  input  logic [XLEN-1:0]      br_target_addr,
  input  logic                 br_mispredict,
  output logic                 cdb_valid,
  output logic [XLEN-1:0]      cdb_data,
  output logic [PREG_W-1:0]    cdb_preg,
  output logic [ROB_TAG_W-1:0] cdb_rob_tag,
  output logic                 cdb_mispredict
);

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [PREG_W-1:0]    preg;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 mispredict;
  } entry_t;

  entry_t                 push_entry [NUM_CDB_SRC];
  entry_t                 head       [NUM_CDB_SRC];
  entry_t                 sel;
  logic [NUM_CDB_SRC-1:0] push;
  logic [NUM_CDB_SRC-1:0] pop;
  logic [NUM_CDB_SRC-1:0] ready;
  logic [NUM_CDB_SRC-1:0] req;
  logic                   any_req;
  src_idx_t               gnt;
  src_idx_t               cand;
  src_idx_t               rr_ptr;

  assign push[SRC_ALU] = alu_cdb_valid;
  assign push[SRC_LSU] = lsu_cdb_valid;
  assign push[SRC_BR]  = br_valid;

  assign push_entry[SRC_ALU] = '{data: alu_cdb_data, preg: alu_cdb_preg,
                                 rob_tag: alu_cdb_tag, mispredict: 1'b0};
  assign push_entry[SRC_LSU] = '{data: lsu_cdb_data, preg: lsu_cdb_preg,
                                 rob_tag: lsu_cdb_tag, mispredict: 1'b0};
  // Branches never write a register; the target rides on the data field.
  assign push_entry[SRC_BR]  = '{data: br_target_addr, preg: '0,
                                 rob_tag: br_rob_tag, mispredict: br_mispredict};

  assign alu_cdb_ready = ready[SRC_ALU];
  assign lsu_cdb_ready = ready[SRC_LSU];
  assign br_ready      = ready[SRC_BR];

  for (genvar g = 0; g < NUM_CDB_SRC; g++) begin : g_src
    cdb_src_queue #(
      .DEPTH   (QDEPTH),
      .entry_t (entry_t)
    ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_i),
      .push       (push[g]),
      .push_entry (push_entry[g]),
      .pop        (pop[g]),
      .ready      (ready[g]),
      .head       (head[g]),
      .nonempty   (req[g])
    );

    assign pop[g] = cdb_valid && (gnt == src_idx_t'(g));
  end

  // First requester at or after rr_ptr, wrapping over the three sources.
  always_comb begin
    any_req = 1'b0;
    gnt     = SRC_ALU;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_CDB_SRC; k++) begin
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        gnt     = cand;
      end
      cand = src_next(cand);
    end
  end

  always_comb begin
    case (gnt)
      SRC_LSU: sel = head[SRC_LSU];
      SRC_BR:  sel = head[SRC_BR];
      default: sel = head[SRC_ALU];
    endcase
  end

  assign cdb_valid      = any_req && !flush_i;
  assign cdb_data       = cdb_valid ? sel.data       : '0;
  assign cdb_preg       = cdb_valid ? sel.preg       : '0;
  assign cdb_rob_tag    = cdb_valid ? sel.rob_tag    : '0;
  assign cdb_mispredict = cdb_valid ? sel.mispredict : 1'b0;

  // Flush suppresses cdb_valid, so the pointer naturally holds across it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SRC_ALU;
    end else if (cdb_valid) begin
      rr_ptr <= src_next(gnt);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, checked
// by a queue-based reference model that predicts every CDB cycle.
module tb_cdb_arbiter;

  localparam int XLEN   = 32;
  localparam int PREG_W = 6;
  localparam int TAG_W  = 4;
  localparam int QDEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush_i;
  logic [2:0]        vld;
  logic [XLEN-1:0]   d [3];
  logic [PREG_W-1:0] p [3];
  logic [TAG_W-1:0]  t [3];
  logic              bmis;
  logic              alu_rdy, lsu_rdy, br_rdy;
  logic              cdb_valid;
  logic [XLEN-1:0]   cdb_data;
  logic [PREG_W-1:0] cdb_preg;
  logic [TAG_W-1:0]  cdb_rob_tag;
  logic              cdb_mispredict;

  cdb_arbiter #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .alu_cdb_valid  (vld[0]),
    .alu_cdb_ready  (alu_rdy),
    .alu_cdb_data   (d[0]),
    .alu_cdb_preg   (p[0]),
    .alu_cdb_tag    (t[0]),
    .lsu_cdb_valid  (vld[1]),
    .lsu_cdb_ready  (lsu_rdy),
    .lsu_cdb_data   (d[1]),
    .lsu_cdb_preg   (p[1]),
    .lsu_cdb_tag    (t[1]),
    .br_valid       (vld[2]),
    .br_ready       (br_rdy),
    .br_rob_tag     (t[2]),
    .br_target_addr (d[2]),
    .br_mispredict  (bmis),
    .cdb_valid      (cdb_valid),
    .cdb_data       (cdb_data),
    .cdb_preg       (cdb_preg),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_mispredict (cdb_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]   data;
    logic [PREG_W-1:0] preg;
    logic [TAG_W-1:0]  tag;
    logic              mis;
  } ent_t;

  ent_t       mq [3][$];   // expected contents of each source queue
  int         m_rr = 0;    // source with priority next cycle
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         win_en = 1'b0;
  int         gcnt [3];
  logic [2:0] acc = 3'b000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: predicts the bus from the expected queues, then applies the
  // effect of the coming edge (accepted pushes, grant pop, flush, reset).
  always @(negedge clk) begin : mon
    logic [2:0] rdyv;
    logic [2:0] take;
    bit         any;
    bit         expv;
    int         g;
    int         gi;
    ent_t       e;
    ent_t       ne;
    rdyv = {br_rdy, lsu_rdy, alu_rdy};
    any  = 1'b0;
    g    = 0;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (!any && mq[s].size() != 0) begin
        any = 1'b1;
        g   = s;
      end
    end
    expv = any && !flush_i;
    if (!reset) begin
      if (expv) e = mq[g][0];
      else begin
        e.data = '0; e.preg = '0; e.tag = '0; e.mis = 1'b0;
      end
      chk("cdb_valid", cdb_valid, expv);
      chk("cdb_data", cdb_data, e.data);
      chk("cdb_preg", cdb_preg, e.preg);
      chk("cdb_rob_tag", cdb_rob_tag, e.tag);
      chk("cdb_mispredict", cdb_mispredict, e.mis);
      for (int s = 0; s < 3; s++) chk("ready", rdyv[s], mq[s].size() != QDEPTH);
      if (win_en && cdb_valid) begin
        gi = int'(cdb_rob_tag[3:2]);
        if (gi < 3) gcnt[gi]++;
      end
    end
    for (int s = 0; s < 3; s++) take[s] = vld[s] && (mq[s].size() < QDEPTH);
    if (reset) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      m_rr = 0;
    end else if (flush_i) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
    end else begin
      if (expv) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % 3;
      end
      for (int s = 0; s < 3; s++) begin
        if (take[s]) begin
          ne.data = d[s];
          ne.preg = (s == 2) ? '0 : p[s];
          ne.tag  = t[s];
          ne.mis  = (s == 2) ? bmis : 1'b0;
          mq[s].push_back(ne);
        end
      end
    end
  end

  task automatic tick();
    acc = vld & {br_rdy, lsu_rdy, alu_rdy};
    @(posedge clk);
    #1;
  endtask

  // Producer model: an offered result stays put until it is accepted.
  task automatic rand_drive(input logic [2:0] want, input bit bl);
    for (int s = 0; s < 3; s++) begin
      if (!(vld[s] && !acc[s])) begin
        vld[s] = want[s];
        d[s]   = $urandom;
        p[s]   = 6'($urandom);
        t[s]   = bl ? {2'(s), 2'($urandom)} : 4'($urandom);
        if (s == 2) bmis = 1'($urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; vld = 3'b000; bmis = 1'b0;
    for (int s = 0; s < 3; s++) begin d[s] = '0; p[s] = '0; t[s] = '0; end
    for (int s = 0; s < 3; s++) gcnt[s] = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // Single ALU result
    vld[0] = 1'b1; d[0] = 32'h0000_002A; p[0] = 6'd5; t[0] = 4'd3;
    tick();
    vld = 3'b000;
    chk("t1_valid", cdb_valid, 1'b1);
    chk("t1_data", cdb_data, 32'h2A);
    chk("t1_preg", cdb_preg, 6'd5);
    chk("t1_tag", cdb_rob_tag, 4'd3);
    chk("t1_mis", cdb_mispredict, 1'b0);
    tick();
    chk("t1_idle", cdb_valid, 1'b0);

    // Move priority back to ALU with a lone branch, then all three at once
    vld[2] = 1'b1; d[2] = 32'h200; t[2] = 4'd9; bmis = 1'b0;
    tick();
    vld = 3'b000;
    tick();
    vld = 3'b111;
    d[0] = 32'h11; p[0] = 6'd1; t[0] = 4'd1;
    d[1] = 32'h22; p[1] = 6'd2; t[1] = 4'd2;
    d[2] = 32'h100; p[2] = 6'd63; t[2] = 4'd3; bmis = 1'b1;
    tick();
    vld = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      chk("t2_order", cdb_rob_tag, k);
      if (k == 3) begin
        chk("t2_br_data", cdb_data, 32'h100);
        chk("t2_br_preg", cdb_preg, 6'd0);
        chk("t2_br_mis", cdb_mispredict, 1'b1);
      end
      tick();
    end

    // Back-to-back pushes on every source, then a 30-cycle fairness window
    repeat (12) begin rand_drive(3'b111, 1'b1); tick(); end
    win_en = 1'b1;
    repeat (30) begin rand_drive(3'b111, 1'b1); tick(); end
    win_en = 1'b0;
    chk("grants_alu", gcnt[0], 10);
    chk("grants_lsu", gcnt[1], 10);
    chk("grants_br", gcnt[2], 10);

    // Flush with queued entries and a concurrent ALU push
    vld = 3'b000; acc = 3'b000;
    repeat (2) begin rand_drive(3'b111, 1'b0); acc = 3'b111; tick(); end
    flush_i = 1'b1; vld = 3'b001; d[0] = 32'hDEAD_BEEF; t[0] = 4'hF;
    tick();
    flush_i = 1'b0; vld = 3'b000;
    chk("flush_next_valid", cdb_valid, 1'b0);
    chk("flush_ready", {br_rdy, lsu_rdy, alu_rdy}, 3'b111);
    repeat (3) tick();

    // Reset with LSU and BR entries pending
    vld = 3'b110; t[1] = 4'd7; t[2] = 4'd8;
    tick();
    vld = 3'b000; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_fields", {cdb_data, cdb_preg, cdb_rob_tag, cdb_mispredict}, '0);
    chk("rst_ready", {br_rdy, lsu_rdy, alu_rdy}, 3'b111);
    vld = 3'b111; t[0] = 4'd4; t[1] = 4'd5; t[2] = 4'd6;
    tick();
    vld = 3'b000;
    chk("rst_first", cdb_rob_tag, 4'd4);
    tick();
    chk("rst_second", cdb_rob_tag, 4'd5);
    tick();

    // Randomized traffic with occasional flush and reset
    acc = 3'b111;
    repeat (2000) begin
      rand_drive(3'($urandom), 1'b0);
      flush_i = ($urandom_range(0, 39) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      tick();
    end
    flush_i = 1'b0; reset = 1'b0; vld = 3'b000;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the ALU, LSU and branch functional units, and upstream of the ROB, the reservation-station wakeup logic and the rename ready-table.
- Each FU writes its result into a small per-source queue.
- A round-robin arbiter selects one queued result per cycle and drives the single global CDB: cdb_valid, cdb_data, cdb_preg, cdb_rob_tag and cdb_mispredict.
- Back-pressure to each FU is provided by a ready signal.

Parameters:
- XLEN, 32, data/address width.
- PREG_W, 6, physical register index width. Index 0 means "no register write".
- ROB_TAG_W, 4, ROB tag width.
- QDEPTH, 2, entries per source queue. Must be 2 or greater, and a power of two.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush from the ROB; discards all queued results
- alu_cdb_valid  in  1  ALU result valid
- alu_cdb_ready  out  1  ALU queue can accept
- alu_cdb_data  in  XLEN  ALU result
- alu_cdb_preg  in  PREG_W  ALU destination physical register
- alu_cdb_tag  in  ROB_TAG_W  ALU ROB tag
- lsu_cdb_valid  in  1  LSU result valid
- lsu_cdb_ready  out  1  LSU queue can accept
- lsu_cdb_data  in  XLEN  load data (stores send preg=0)
- lsu_cdb_preg  in  PREG_W  LSU destination physical register
- lsu_cdb_tag  in  ROB_TAG_W  LSU ROB tag
- br_valid  in  1  branch resolved
- br_ready  out  1  branch queue can accept
- br_rob_tag  in  ROB_TAG_W  branch ROB tag
- br_target_addr  in  XLEN  resolved target address
- br_mispredict  in  1  misprediction flag
- cdb_valid  out  1  broadcast valid
- cdb_data  out  XLEN  broadcast data
- cdb_preg  out  PREG_W  broadcast physical register (0 means none)
- cdb_rob_tag  out  ROB_TAG_W  broadcast ROB tag
- cdb_mispredict  out  1  set only for branch entries with br_mispredict=1

Behaviour:
- Sources are indexed ALU=0, LSU=1, BR=2. Each source has its own FIFO of QDEPTH entries, with read pointer, write pointer and count.
- Enqueue:
  - Occurs when valid and ready are both high at the clk edge.
  - ready = (count != QDEPTH), derived from registered count only. A full queue refuses even in a cycle where it dequeues; there is no combinational path from grant to ready.
  - A branch entry stores data=br_target_addr, preg=0 and mispredict=br_mispredict. ALU and LSU entries store mispredict=0.
- Arbitration (combinational over queue heads):
  - Request per source = count != 0.
  - The search starts at rr_ptr (0..2) and proceeds upward modulo 3; the first requester is granted.
  - cdb_* outputs carry the granted head.
  - cdb_valid = any request and !flush_i.
  - When cdb_valid=0, the data, preg, tag and mispredict outputs are driven to 0.
- Dequeue and pointer update:
  - On a grant, that queue pops at the clk edge.
  - rr_ptr becomes (granted+1) mod 3.
  - With no grant, rr_ptr holds.
- Latency:
  - A result accepted at edge N is broadcast in the cycle after N at the earliest.
  - Throughput is 1 result per cycle in total.
  - With all three queues backlogged, each source wins at least once every 3 cycles.
- Simultaneous events:
  - Enqueue and dequeue on the same queue in the same cycle: count is unchanged and both pointers advance.
  - Pointer wrap uses QDEPTH-modulo arithmetic.
- Flush:
  - When flush_i=1 at an edge, all counts and pointers clear to 0.
  - Enqueues in that cycle are dropped.
  - cdb_valid is 0 during that cycle.
  - rr_ptr is held.
- Reset:
  - Counts, pointers and rr_ptr go to 0.
  - All ready outputs read 1 in the first cycle after reset.
  - All cdb_* outputs are 0.
  - Reset asserted mid-operation discards all queued results; reset has priority over flush_i.
- The unit never checks tags. Duplicate tags pass through unchanged.

Decomposition:
- Shared package holds:
  - typedef cdb_entry_t = {data, preg, rob_tag, mispredict}
  - localparams NUM_CDB_SRC=3 and SRC_ALU/SRC_LSU/SRC_BR
- One sub-module: cdb_src_queue.
  - Parameterised FIFO of cdb_entry_t with push, pop, flush, ready, head and nonempty.
  - Instantiated three times.
- Arbiter and round-robin pointer live in cdb_arbiter.

Test Plan:
- Single ALU result: data=0x0000002A, preg=5, tag=3 at cycle 10. Required: cdb_valid=1 in cycle 11 with the same fields, mispredict=0, and cdb_valid=0 in cycle 12.
- Simultaneous ALU (tag 1), LSU (tag 2) and BR (tag 3, target=0x00000100, mispredict=1) with rr_ptr=0. Required: CDB order over 3 consecutive cycles is tag 1, 2, 3. The third broadcast has data=0x100, preg=0 and mispredict=1.
- Hold the ALU queue head (lsu/br keep requesting) and push ALU for 3 consecutive cycles with QDEPTH=2. Required: alu_cdb_ready=0 after 2 accepts, the third push is held by the FU, and all accepted results appear in FIFO order with none lost or duplicated.
- Continuous back-to-back traffic on all sources for 30 cycles. Required: each source granted exactly 10 times, rr_ptr rotation 0→1→2, and no grant gap greater than 3 cycles.
- Queues holding 4 entries, then flush_i=1 for one cycle together with a new ALU push. Required: cdb_valid=0 that cycle and the next, all ready=1 afterwards, and the pushed entry never broadcast.
- Reset asserted for 1 cycle with BR and LSU queues non-empty. Required: all cdb_* outputs=0 and all ready=1 after reset, and the first post-reset ALU push is broadcast with rr_ptr=0 priority.
